// File: rtl/arbitro_mem_offchip.sv
// Round-robin arbiter sharing one off-chip memory port between a pixel reader
// and a result writer, with a per-operation completion timeout.
module arbitro_mem_offchip #(
  parameter int BITS_MEMORY_DATA      = 32,
  parameter int BITS_ADDR_MEM_OFFCHIP = 14,
  parameter int CICLOS_TIMEOUT        = 255
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             req_lectura,
  input  logic [BITS_ADDR_MEM_OFFCHIP-1:0] address_lectura,
  input  logic                             req_escritura,
  input  logic [BITS_ADDR_MEM_OFFCHIP-1:0] address_escritura,
  input  logic [BITS_MEMORY_DATA-1:0]      data_escritura,
  input  logic                             op_complete_mem,
  input  logic [BITS_MEMORY_DATA-1:0]      data_mem,
  output logic                             read_mem,
  output logic                             write_mem,
  output logic [BITS_ADDR_MEM_OFFCHIP-1:0] address_mem,
  output logic [BITS_MEMORY_DATA-1:0]      write_data_mem,
  output logic                             complete_lectura,
  output logic                             complete_escritura,
  output logic [BITS_MEMORY_DATA-1:0]      data_lectura,
  output logic                             error_timeout
);

  localparam int CW = $clog2(CICLOS_TIMEOUT + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(CICLOS_TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE,
    LECTURA,
    ESCRITURA,
    FIN
  } estado_t;

  estado_t       estado;
  logic          prioridad;
  logic [CW-1:0] cnt;
  logic          grant_lec;
  logic          cnt_fin;

  // prioridad=0 favours the reader on contention
  assign grant_lec = req_lectura & (~req_escritura | ~prioridad);
  assign cnt_fin   = (cnt == CNT_LAST);

  always_ff @(posedge clk) begin
    if (!reset) begin
      estado             <= IDLE;
      prioridad          <= 1'b0;
      cnt                <= '0;
      read_mem           <= 1'b0;
      write_mem          <= 1'b0;
      address_mem        <= '0;
      write_data_mem     <= '0;
      complete_lectura   <= 1'b0;
      complete_escritura <= 1'b0;
      data_lectura       <= '0;
      error_timeout      <= 1'b0;
    end else begin
      unique case (estado)
        IDLE: begin
          if (grant_lec) begin
            estado      <= LECTURA;
            read_mem    <= 1'b1;
            address_mem <= address_lectura;
            cnt         <= '0;
            if (req_escritura) prioridad <= 1'b1;
          end else if (req_escritura) begin
            estado         <= ESCRITURA;
            write_mem      <= 1'b1;
            address_mem    <= address_escritura;
            write_data_mem <= data_escritura;
            cnt            <= '0;
            if (req_lectura) prioridad <= 1'b0;
          end
        end
        LECTURA: begin
          if (op_complete_mem) begin
            data_lectura     <= data_mem;
            read_mem         <= 1'b0;
            complete_lectura <= 1'b1;
            estado           <= FIN;
          end else if (cnt_fin) begin
            read_mem         <= 1'b0;
            complete_lectura <= 1'b1;
            error_timeout    <= 1'b1;
            estado           <= FIN;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        ESCRITURA: begin
          if (op_complete_mem) begin
            write_mem          <= 1'b0;
            complete_escritura <= 1'b1;
            estado             <= FIN;
          end else if (cnt_fin) begin
            write_mem          <= 1'b0;
            complete_escritura <= 1'b1;
            error_timeout      <= 1'b1;
            estado             <= FIN;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        FIN: begin
          complete_lectura   <= 1'b0;
          complete_escritura <= 1'b0;
          error_timeout      <= 1'b0;
          estado             <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_arbitro_mem_offchip.sv
// Scenario bench: completions checked against a queue of expected results
// pushed as requests are issued; command timing checked inline.
module tb_arbitro_mem_offchip;

  localparam int DW = 32;
  localparam int AW = 14;
  localparam int TO = 8;

  typedef struct {
    bit          is_read;
    logic [31:0] data;
    bit          err;
  } exp_t;

  logic          clk = 1'b0;
  logic          reset;
  logic          req_lectura;
  logic [AW-1:0] address_lectura;
  logic          req_escritura;
  logic [AW-1:0] address_escritura;
  logic [DW-1:0] data_escritura;
  logic          op_complete_mem;
  logic [DW-1:0] data_mem;
  logic          read_mem;
  logic          write_mem;
  logic [AW-1:0] address_mem;
  logic [DW-1:0] write_data_mem;
  logic          complete_lectura;
  logic          complete_escritura;
  logic [DW-1:0] data_lectura;
  logic          error_timeout;

  int   vectors = 0;
  int   miscompares = 0;
  exp_t sb[$];
  logic [31:0] last_rd = 32'h0;

  arbitro_mem_offchip #(
    .BITS_MEMORY_DATA(DW),
    .BITS_ADDR_MEM_OFFCHIP(AW),
    .CICLOS_TIMEOUT(TO)
  ) dut (
    .clk(clk),
    .reset(reset),
    .req_lectura(req_lectura),
    .address_lectura(address_lectura),
    .req_escritura(req_escritura),
    .address_escritura(address_escritura),
    .data_escritura(data_escritura),
    .op_complete_mem(op_complete_mem),
    .data_mem(data_mem),
    .read_mem(read_mem),
    .write_mem(write_mem),
    .address_mem(address_mem),
    .write_data_mem(write_data_mem),
    .complete_lectura(complete_lectura),
    .complete_escritura(complete_escritura),
    .data_lectura(data_lectura),
    .error_timeout(error_timeout)
  );

  always #5 clk = ~clk;

  // Completion monitor: pops the scoreboard on every completion pulse
  always @(negedge clk) begin
    exp_t e;
    if (read_mem === 1'b1 && write_mem === 1'b1) begin
      miscompares++;
      $display("FAIL overlap: read_mem=1 write_mem=1 required not both");
    end
    if (complete_lectura === 1'b1 || complete_escritura === 1'b1) begin
      vectors++;
      if (sb.size() == 0) begin
        miscompares++;
        $display("FAIL unexpected_complete: lec=%b esc=%b required none",
                 complete_lectura, complete_escritura);
      end else begin
        e = sb.pop_front();
        if (complete_lectura !== e.is_read ||
            complete_escritura !== !e.is_read ||
            error_timeout !== e.err ||
            (e.is_read && data_lectura !== e.data)) begin
          miscompares++;
          $display("FAIL completion: lec=%b esc=%b err=%b data=%h required lec=%b esc=%b err=%b data=%h",
                   complete_lectura, complete_escritura, error_timeout, data_lectura,
                   e.is_read, !e.is_read, e.err, e.data);
        end
      end
    end
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic test_reset();
    vectors++;
    if ({read_mem, write_mem, complete_lectura, complete_escritura, error_timeout} !== 5'b0) begin
      miscompares++;
      $display("FAIL reset_ctrl: got %b required 00000",
               {read_mem, write_mem, complete_lectura, complete_escritura, error_timeout});
    end
    vectors++;
    if (address_mem !== '0 || write_data_mem !== '0 || data_lectura !== '0) begin
      miscompares++;
      $display("FAIL reset_data: addr=%h wdata=%h rdata=%h required 0",
               address_mem, write_data_mem, data_lectura);
    end
  endtask

  task automatic test_single_read();
    tick();
    req_lectura = 1'b1;
    address_lectura = 14'h0010;
    sb.push_back('{1'b1, 32'hA1B2C3D4, 1'b0});
    tick();
    vectors++;
    if (read_mem !== 1'b1 || write_mem !== 1'b0 || address_mem !== 14'h0010) begin
      miscompares++;
      $display("FAIL read_grant: rd=%b wr=%b addr=%h required 1 0 0010",
               read_mem, write_mem, address_mem);
    end
    address_lectura = 14'h3FFF;
    tick();
    vectors++;
    if (address_mem !== 14'h0010 || read_mem !== 1'b1) begin
      miscompares++;
      $display("FAIL read_hold: addr=%h rd=%b required 0010 1", address_mem, read_mem);
    end
    tick();
    op_complete_mem = 1'b1;
    data_mem = 32'hA1B2C3D4;
    tick();
    op_complete_mem = 1'b0;
    req_lectura = 1'b0;
    last_rd = 32'hA1B2C3D4;
    vectors++;
    if (read_mem !== 1'b0) begin
      miscompares++;
      $display("FAIL read_drop: rd=%b required 0", read_mem);
    end
    tick();
    vectors++;
    if (complete_lectura !== 1'b0 || data_lectura !== 32'hA1B2C3D4) begin
      miscompares++;
      $display("FAIL read_fin_len: cl=%b data=%h required 0 a1b2c3d4",
               complete_lectura, data_lectura);
    end
  endtask

  task automatic test_write();
    tick();
    req_escritura = 1'b1;
    address_escritura = 14'h0100;
    data_escritura = 32'h55;
    sb.push_back('{1'b0, 32'h0, 1'b0});
    tick();
    vectors++;
    if (write_mem !== 1'b1 || read_mem !== 1'b0 ||
        address_mem !== 14'h0100 || write_data_mem !== 32'h55) begin
      miscompares++;
      $display("FAIL write_grant: wr=%b rd=%b addr=%h wd=%h required 1 0 0100 00000055",
               write_mem, read_mem, address_mem, write_data_mem);
    end
    data_escritura = 32'h99;
    tick();
    op_complete_mem = 1'b1;
    data_mem = 32'h12345678;
    tick();
    op_complete_mem = 1'b0;
    req_escritura = 1'b0;
    vectors++;
    if (write_mem !== 1'b0 || data_lectura !== last_rd) begin
      miscompares++;
      $display("FAIL write_drop: wr=%b rdata=%h required 0 %h", write_mem, data_lectura, last_rd);
    end
    tick();
  endtask

  task automatic test_contention();
    int n;
    tick();
    req_lectura = 1'b1;
    address_lectura = 14'h0020;
    req_escritura = 1'b1;
    address_escritura = 14'h0100;
    data_escritura = 32'h55;
    for (int k = 0; k < 4; k++)
      sb.push_back('{(k % 2 == 0), 32'h1000 + k, 1'b0});
    for (int k = 0; k < 4; k++) begin
      n = 0;
      do begin
        tick();
        n++;
      end while (read_mem !== 1'b1 && write_mem !== 1'b1 && n < 6);
      vectors++;
      if (read_mem !== (k % 2 == 0) || write_mem !== (k % 2 != 0) ||
          address_mem !== ((k % 2 == 0) ? 14'h0020 : 14'h0100)) begin
        miscompares++;
        $display("FAIL contention_grant%0d: rd=%b wr=%b addr=%h after %0d cycles",
                 k, read_mem, write_mem, address_mem, n);
      end
      op_complete_mem = 1'b1;
      data_mem = 32'h1000 + k;
      tick();
      op_complete_mem = 1'b0;
      if (k % 2 == 0) last_rd = 32'h1000 + k;
    end
    req_lectura = 1'b0;
    req_escritura = 1'b0;
    tick();
  endtask

  task automatic test_timeout();
    int n;
    tick();
    req_lectura = 1'b1;
    address_lectura = 14'h0033;
    sb.push_back('{1'b1, last_rd, 1'b1});
    tick();
    n = 0;
    while (read_mem === 1'b1 && n < 20) begin
      n++;
      tick();
    end
    req_lectura = 1'b0;
    vectors++;
    if (n != TO || error_timeout !== 1'b1) begin
      miscompares++;
      $display("FAIL timeout_len: read_mem high %0d cycles err=%b required %0d 1",
               n, error_timeout, TO);
    end
    tick();
    vectors++;
    if (error_timeout !== 1'b0 || complete_lectura !== 1'b0) begin
      miscompares++;
      $display("FAIL timeout_pulse: err=%b cl=%b required 0 0", error_timeout, complete_lectura);
    end
  endtask

  task automatic test_timeout_boundary();
    tick();
    req_lectura = 1'b1;
    address_lectura = 14'h0044;
    sb.push_back('{1'b1, 32'hCAFE0001, 1'b0});
    tick();
    repeat (TO - 1) tick();
    vectors++;
    if (read_mem !== 1'b1) begin
      miscompares++;
      $display("FAIL boundary_hold: rd=%b required 1", read_mem);
    end
    op_complete_mem = 1'b1;
    data_mem = 32'hCAFE0001;
    tick();
    op_complete_mem = 1'b0;
    req_lectura = 1'b0;
    last_rd = 32'hCAFE0001;
    vectors++;
    if (read_mem !== 1'b0 || error_timeout !== 1'b0) begin
      miscompares++;
      $display("FAIL boundary_done: rd=%b err=%b required 0 0", read_mem, error_timeout);
    end
    tick();
  endtask

  task automatic test_stray();
    tick();
    op_complete_mem = 1'b1;
    data_mem = 32'hFFFFFFFF;
    tick();
    op_complete_mem = 1'b0;
    tick();
    vectors++;
    if (data_lectura !== last_rd ||
        {read_mem, write_mem, complete_lectura, complete_escritura, error_timeout} !== 5'b0) begin
      miscompares++;
      $display("FAIL stray: rdata=%h ctrl=%b required %h 00000",
               data_lectura,
               {read_mem, write_mem, complete_lectura, complete_escritura, error_timeout},
               last_rd);
    end
  endtask

  task automatic test_reset_mid_write();
    int n;
    tick();
    req_escritura = 1'b1;
    address_escritura = 14'h0155;
    data_escritura = 32'hDEADBEEF;
    tick();
    vectors++;
    if (write_mem !== 1'b1) begin
      miscompares++;
      $display("FAIL rst_wr_grant: wr=%b required 1", write_mem);
    end
    reset = 1'b0;
    tick();
    reset = 1'b1;
    vectors++;
    if (write_mem !== 1'b0 || complete_escritura !== 1'b0 || data_lectura !== '0) begin
      miscompares++;
      $display("FAIL rst_wr_abort: wr=%b ce=%b rdata=%h required 0 0 0",
               write_mem, complete_escritura, data_lectura);
    end
    sb.push_back('{1'b0, 32'h0, 1'b0});
    n = 0;
    do begin
      tick();
      n++;
    end while (write_mem !== 1'b1 && n < 5);
    vectors++;
    if (write_mem !== 1'b1 || address_mem !== 14'h0155 || write_data_mem !== 32'hDEADBEEF || n != 1) begin
      miscompares++;
      $display("FAIL rst_wr_regrant: wr=%b addr=%h wd=%h after %0d required 1 0155 deadbeef 1",
               write_mem, address_mem, write_data_mem, n);
    end
    op_complete_mem = 1'b1;
    tick();
    op_complete_mem = 1'b0;
    req_escritura = 1'b0;
    tick();
  endtask

  initial begin
    reset = 1'b0;
    req_lectura = 1'b0;
    address_lectura = '0;
    req_escritura = 1'b0;
    address_escritura = '0;
    data_escritura = '0;
    op_complete_mem = 1'b0;
    data_mem = '0;
    repeat (3) tick();
    test_reset();
    reset = 1'b1;
    test_single_read();
    test_write();
    test_contention();
    test_timeout();
    test_timeout_boundary();
    test_stray();
    test_reset_mid_write();
    tick();
    vectors++;
    if (sb.size() != 0) begin
      miscompares++;
      $display("FAIL scoreboard_drain: %0d pending required 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/arbitro_mem_offchip.md
ARBITRO_MEM_OFFCHIP -- requirements
Module: arbitro_mem_offchip

Interface
REQ-001 Parameter BITS_MEMORY_DATA, default 32: memory data word width.
REQ-002 Parameter BITS_ADDR_MEM_OFFCHIP, default 14: off-chip memory address width.
REQ-003 Parameter CICLOS_TIMEOUT, default 255: maximum cycles a granted operation may wait for op_complete_mem.
REQ-004 clk  input  1  single clock; all logic on its rising edge.
REQ-005 reset  input  1  synchronous, active-low reset.
REQ-006 req_lectura  input  1  pixel-fetch read request, level; held until complete_lectura.
REQ-007 address_lectura  input  BITS_ADDR_MEM_OFFCHIP  read address; stable while req_lectura is high.
REQ-008 req_escritura  input  1  result write-back request, level; held until complete_escritura.
REQ-009 address_escritura  input  BITS_ADDR_MEM_OFFCHIP  write address; stable while req_escritura is high.
REQ-010 data_escritura  input  BITS_MEMORY_DATA  write data; stable while req_escritura is high.
REQ-011 op_complete_mem  input  1  memory completion pulse for the current operation.
REQ-012 data_mem  input  BITS_MEMORY_DATA  memory read data; valid when op_complete_mem is high.
REQ-013 read_mem, write_mem  output  1 each  memory commands.
REQ-014 address_mem  output  BITS_ADDR_MEM_OFFCHIP  memory address.
REQ-015 write_data_mem  output  BITS_MEMORY_DATA  memory write data.
REQ-016 complete_lectura, complete_escritura  output  1 each  one-cycle completion pulse to the owning requester.
REQ-017 data_lectura  output  BITS_MEMORY_DATA  registered read data; valid while complete_lectura is high.
REQ-018 error_timeout  output  1  one-cycle pulse, coincident with the aborted requester's complete pulse.

Function
REQ-019 FSM states: IDLE, LECTURA, ESCRITURA, FIN; all outputs registered.
REQ-020 IDLE, only req_lectura high -> LECTURA; only req_escritura high -> ESCRITURA; neither high -> stay in IDLE.
REQ-021 IDLE, both requests high -> grant the side named by register prioridad; prioridad resets to lectura.
REQ-022 On each grant, prioridad flips to the other side (round-robin); prioridad is unchanged when only one side requests.
REQ-023 On grant, capture the address (and write data) into address_mem/write_data_mem; assert read_mem or write_mem starting the cycle after the request is sampled.
REQ-024 The command, address and data outputs stay constant until op_complete_mem or timeout; requester input changes during the operation are ignored.
REQ-025 LECTURA, op_complete_mem=1 -> latch data_mem into data_lectura, drop read_mem, go to FIN with complete_lectura=1.
REQ-026 ESCRITURA, op_complete_mem=1 -> drop write_mem, go to FIN with complete_escritura=1.
REQ-027 FIN lasts exactly one cycle; the completion pulse is high only in FIN; FIN -> IDLE unconditionally, with requests ignored in FIN.
REQ-028 A held request is re-evaluated in IDLE, so minimum spacing between back-to-back operations from one requester is 1 idle cycle.
REQ-029 Timeout counter clears on grant and increments every cycle in LECTURA/ESCRITURA.
REQ-030 When the counter reaches CICLOS_TIMEOUT without op_complete_mem -> drop the command, go to FIN, pulse the owner's complete plus error_timeout; data_lectura keeps its previous value.
REQ-031 op_complete_mem in IDLE or FIN is ignored and leaves data_lectura unchanged.
REQ-032 op_complete_mem arriving in the same cycle the counter reaches CICLOS_TIMEOUT counts as normal completion, with no error.
REQ-033 read_mem and write_mem are never high together.

Reset
REQ-034 With reset=0 at a rising edge: state IDLE, prioridad=lectura, counter=0, every output 0 including data_lectura.
REQ-035 Reset mid-operation abandons the operation with no completion pulse; arbitration resumes from IDLE after reset is released.

Verification
REQ-036 Single read: req_lectura=1, address_lectura=0x0010 at edge 0; memory answers op_complete_mem with data_mem=0xA1B2C3D4 three cycles later -> read_mem=1/address_mem=0x0010 from cycle 1; complete_lectura pulses 1 cycle after op_complete_mem with data_lectura=0xA1B2C3D4.
REQ-037 Contention: both requests held continuously, writer at 0x0100 with data 0x55 -> grants alternate lectura, escritura, lectura, …, with no overlap of read_mem and write_mem.
REQ-038 Timeout: read granted, op_complete_mem never asserted, CICLOS_TIMEOUT=8 -> read_mem drops after 8 cycles; complete_lectura and error_timeout pulse together; data_lectura unchanged.
REQ-039 Stray completion: op_complete_mem pulsed in IDLE with data_mem=0xFFFFFFFF -> no outputs change.
REQ-040 Reset during a write (reset=0 for one cycle) -> write_mem=0 the next cycle, no complete_escritura; a held req_escritura is re-granted after reset is released.
